// File: rtl/sprite_blitter.sv
// sprite_blitter: palette-indexed sprite blitter with canvas clear.
// Streams a spritesheet frame through a fixed-latency ROM into the frame buffer.
module sprite_blitter #(
  parameter int SPRITE_FRAME_WIDTH  = 64,
  parameter int SPRITE_FRAME_HEIGHT = 64,
  parameter int NUM_FRAMES          = 512,
  parameter int CANVAS_WIDTH        = 360,
  parameter int CANVAS_HEIGHT       = 720,
  parameter int PALETTE_SIZE        = 8,
  parameter int TRANSPARENT_INDEX   = 0,
  parameter int BG_INDEX            = PALETTE_SIZE - 1,
  parameter int ROM_LATENCY         = 2
) (
  input  logic clk_pixel,
  input  logic sys_rst,
  input  logic clear_req,
  output logic clear_busy,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic signed [$clog2(CANVAS_WIDTH):0] cmd_x,
  input  logic signed [$clog2(CANVAS_HEIGHT):0] cmd_y,
  input  logic [$clog2(NUM_FRAMES)-1:0] cmd_frame,
  input  logic cmd_hflip,
  output logic [$clog2(NUM_FRAMES*SPRITE_FRAME_WIDTH*SPRITE_FRAME_HEIGHT)-1:0] sheet_addr,
  input  logic [$clog2(PALETTE_SIZE)-1:0] sheet_data,
  output logic fb_we,
  output logic [$clog2(CANVAS_WIDTH*CANVAS_HEIGHT)-1:0] fb_addr,
  output logic [$clog2(PALETTE_SIZE)-1:0] fb_din,
  output logic done
);

  localparam int W   = SPRITE_FRAME_WIDTH;
  localparam int H   = SPRITE_FRAME_HEIGHT;
  localparam int CW  = CANVAS_WIDTH;
  localparam int CH  = CANVAS_HEIGHT;
  localparam int L   = ROM_LATENCY;
  localparam int PW  = $clog2(PALETTE_SIZE);
  localparam int XW  = $clog2(CW) + 1;
  localparam int YW  = $clog2(CH) + 1;
  localparam int FW  = $clog2(NUM_FRAMES);
  localparam int SAW = $clog2(NUM_FRAMES * W * H);
  localparam int AW  = $clog2(CW * CH);
  localparam int UW  = $clog2(W);
  localparam int VW  = $clog2(H);
  localparam int DW  = $clog2(L + 1);
  // wide enough for cmd_x + u without wrap
  localparam int SXW = ((XW > UW + 1) ? XW : UW + 1) + 1;
  localparam int SYW = ((YW > VW + 1) ? YW : VW + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    BLIT,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic signed [XW-1:0] x_q;
  logic signed [YW-1:0] y_q;
  logic [FW-1:0] frame_q;
  logic hflip_q;
  logic [UW-1:0] u_q;
  logic [VW-1:0] v_q;
  logic [UW-1:0] col;
  logic [AW-1:0] clr_q;
  logic [DW-1:0] drn_q;
  logic accept;
  logic clr_last;
  logic blit_last;
  logic drn_last;
  logic done_d;
  logic done_q;

  logic [L-1:0] pv_q;
  logic signed [SXW-1:0] px_q [L];
  logic signed [SYW-1:0] py_q [L];
  logic signed [SXW-1:0] tx, dx;
  logic signed [SYW-1:0] ty, dy;
  logic in_range;

  assign clr_last  = clr_q == AW'(CW * CH - 1);
  assign blit_last = (u_q == UW'(W - 1)) && (v_q == VW'(H - 1));
  assign drn_last  = drn_q == DW'(L - 1);
  assign done      = done_q;

  // State register and retire pulse
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state and handshake decode; clear wins over a command
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    clear_busy = 1'b0;
    accept     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = !clear_req;
        if (clear_req) begin
          state_d = CLEAR;
        end else if (cmd_valid) begin
          accept  = 1'b1;
          state_d = BLIT;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        if (clr_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      BLIT: begin
        if (blit_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drn_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and walk counters
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      hflip_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      clr_q   <= '0;
      drn_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          u_q   <= '0;
          v_q   <= '0;
          clr_q <= '0;
          drn_q <= '0;
          if (accept) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            frame_q <= cmd_frame;
            hflip_q <= cmd_hflip;
          end
        end
        CLEAR: clr_q <= clr_q + 1'b1;
        BLIT: begin
          if (u_q == UW'(W - 1)) begin
            u_q <= '0;
            v_q <= blit_last ? '0 : v_q + 1'b1;
          end else begin
            u_q <= u_q + 1'b1;
          end
        end
        DRAIN: drn_q <= drn_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign col = hflip_q ? UW'(W - 1) - u_q : u_q;
  assign tx  = SXW'(x_q) + SXW'($signed({1'b0, u_q}));
  assign ty  = SYW'(y_q) + SYW'($signed({1'b0, v_q}));

  // Spritesheet read address, parked at zero when not blitting
  always_comb begin
    sheet_addr = '0;
    if (state_q == BLIT) begin
      sheet_addr = SAW'(frame_q) * SAW'(W * H)
                 + SAW'(v_q) * SAW'(W)
                 + SAW'(col);
    end
  end

  // Valid bits travel with the ROM read
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= state_q == BLIT;
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  // Target coordinates travel with the ROM read
  always_ff @(posedge clk_pixel) begin
    px_q[0] <= tx;
    py_q[0] <= ty;
    for (int i = 1; i < L; i++) begin
      px_q[i] <= px_q[i-1];
      py_q[i] <= py_q[i-1];
    end
  end

  assign dx = px_q[L-1];
  assign dy = py_q[L-1];
  assign in_range = !dx[SXW-1] && (dx < SXW'(CW))
                 && !dy[SYW-1] && (dy < SYW'(CH));

  // Frame-buffer write port: clear stream or clipped opaque pixel
  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_din  = '0;
    if (state_q == CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_q;
      fb_din  = PW'(BG_INDEX);
    end else if (pv_q[L-1] && in_range
                 && sheet_data != PW'(TRANSPARENT_INDEX)) begin
      fb_we   = 1'b1;
      fb_addr = AW'(dy) * AW'(CW) + AW'(dx);
      fb_din  = sheet_data;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table, hand sequences and random blits
// checked against a whole-image reference model.
module tb_sprite_blitter;

  localparam int W = 4;
  localparam int H = 4;
  localparam int CW = 8;
  localparam int CH = 4;
  localparam int NF = 4;
  localparam int L = 2;
  localparam int BG = 7;
  localparam int NPIX = CW * CH;
  localparam int BLAT = W * H + L + 1;
  localparam int CLAT = NPIX + 1;

  typedef struct {
    bit clr;
    int x;
    int y;
    int f;
    bit h;
    int lat;
  } vec_t;

  logic clk_pixel = 1'b0;
  logic sys_rst = 1'b1;
  logic clear_req = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_hflip = 1'b0;
  logic signed [3:0] cmd_x = '0;
  logic signed [2:0] cmd_y = '0;
  logic [1:0] cmd_frame = '0;
  logic clear_busy, cmd_ready, fb_we, done;
  logic [5:0] sheet_addr;
  logic [2:0] sheet_data, fb_din;
  logic [4:0] fb_addr;

  logic [2:0] rom [NF*W*H];
  logic [2:0] rd1, rd2;
  logic [2:0] dut_fb [NPIX];
  logic [2:0] ref_fb [NPIX];

  int cyc = 0;
  int acc_log[$];
  int done_log[$];
  int wa_log[$];
  int wd_log[$];
  int busy_ready = 0;
  int idle_we = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_pixel = ~clk_pixel;

  sprite_blitter #(
    .SPRITE_FRAME_WIDTH(W),
    .SPRITE_FRAME_HEIGHT(H),
    .NUM_FRAMES(NF),
    .CANVAS_WIDTH(CW),
    .CANVAS_HEIGHT(CH),
    .PALETTE_SIZE(8),
    .TRANSPARENT_INDEX(0),
    .BG_INDEX(BG),
    .ROM_LATENCY(L)
  ) dut (
    .clk_pixel(clk_pixel),
    .sys_rst(sys_rst),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_frame(cmd_frame),
    .cmd_hflip(cmd_hflip),
    .sheet_addr(sheet_addr),
    .sheet_data(sheet_data),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_din(fb_din),
    .done(done)
  );

  // Two-cycle spritesheet ROM
  always @(posedge clk_pixel) begin
    rd1 <= rom[sheet_addr];
    rd2 <= rd1;
  end
  assign sheet_data = rd2;

  // Bus monitor: captured frame buffer and event logs
  always @(posedge clk_pixel) begin
    if (fb_we) begin
      dut_fb[fb_addr] <= fb_din;
      wa_log.push_back(int'(fb_addr));
      wd_log.push_back(int'(fb_din));
    end
    if ((cmd_valid && cmd_ready) || (clear_req && !clear_busy))
      acc_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (clear_busy && cmd_ready) busy_ready <= busy_ready + 1;
    if (fb_we && cmd_ready) idle_we <= idle_we + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input vec_t t, output int nw);
    int p, px, py;
    nw = 0;
    if (t.clr) begin
      foreach (ref_fb[i]) ref_fb[i] = 3'(BG);
      nw = NPIX;
    end else begin
      for (int v = 0; v < H; v++) begin
        for (int u = 0; u < W; u++) begin
          p = int'(rom[t.f*W*H + v*W + (t.h ? W-1-u : u)]);
          px = t.x + u;
          py = t.y + v;
          if (p != 0 && px >= 0 && px < CW && py >= 0 && py < CH) begin
            ref_fb[py*CW + px] = 3'(p);
            nw++;
          end
        end
      end
    end
  endtask

  task automatic clr_logs();
    acc_log.delete();
    done_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic img_chk(input string nm);
    int bad = 0;
    foreach (ref_fb[i]) if (dut_fb[i] !== ref_fb[i]) bad++;
    chk({nm, " image"}, bad, 0);
  endtask

  task automatic do_op(input vec_t t, input string nm);
    int nw;
    int t0 = 0;
    clr_logs();
    @(negedge clk_pixel);
    if (t.clr) begin
      clear_req = 1'b1;
    end else begin
      cmd_valid = 1'b1;
      cmd_x = 4'(t.x);
      cmd_y = 3'(t.y);
      cmd_frame = 2'(t.f);
      cmd_hflip = t.h;
    end
    @(negedge clk_pixel);
    clear_req = 1'b0;
    cmd_valid = 1'b0;
    while (done_log.size() == 0 && t0 < 100) begin
      @(negedge clk_pixel);
      t0++;
    end
    repeat (4) @(negedge clk_pixel);
    model(t, nw);
    chk({nm, " accepts"}, acc_log.size(), 1);
    chk({nm, " dones"}, done_log.size(), 1);
    chk({nm, " latency"},
        (done_log.size() > 0 && acc_log.size() > 0) ?
        done_log[0] - acc_log[0] : -1, t.lat);
    chk({nm, " writes"}, wa_log.size(), nw);
    img_chk(nm);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int bad, nw, t0, nwr;

    foreach (rom[i]) rom[i] = 3'($urandom_range(0, 7));
    rom[16] = 3'd0;
    rom[33] = 3'd5;
    for (int i = 48; i < 64; i++) rom[i] = 3'($urandom_range(1, 7));
    foreach (dut_fb[i]) begin
      dut_fb[i] = '0;
      ref_fb[i] = '0;
    end

    tbl[0] = '{1, 0, 0, 0, 0, CLAT};
    tbl[1] = '{0, 0, 0, 3, 0, BLAT};
    tbl[2] = '{0, -4, 0, 0, 0, BLAT};
    tbl[3] = '{0, 0, -4, 1, 1, BLAT};
    tbl[4] = '{0, 5, 1, 3, 1, BLAT};
    tbl[5] = '{0, -3, -2, 2, 0, BLAT};
    tbl[6] = '{0, 7, 3, 0, 1, BLAT};
    tbl[7] = '{1, 0, 0, 0, 0, CLAT};

    repeat (3) @(negedge clk_pixel);
    sys_rst = 1'b0;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst clear_busy", clear_busy, 0);
    chk("rst done", done, 0);
    chk("rst fb_we", fb_we, 0);
    chk("rst sheet_addr", sheet_addr, 0);

    do_op('{1, 0, 0, 0, 0, CLAT}, "clear");
    bad = 0;
    for (int i = 0; i < wa_log.size(); i++)
      if (wa_log[i] != i || wd_log[i] != BG) bad++;
    chk("clear seq", bad, 0);

    for (int i = 0; i < 8; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

    do_op('{0, 2, 3, 1, 0, BLAT}, "transp");
    bad = 0;
    foreach (wa_log[i]) if (wa_log[i] == 3*CW + 2) bad++;
    chk("transp no px26", bad, 0);
    chk("transp px26 bg", dut_fb[26], BG);

    do_op('{0, -2, 0, 2, 1, BLAT}, "flip");
    chk("flip x0 col", dut_fb[0], 5);

    // clear and command raised together
    clr_logs();
    @(negedge clk_pixel);
    clear_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_x = 4'sd1;
    cmd_y = 3'sd0;
    cmd_frame = 2'd3;
    cmd_hflip = 1'b0;
    @(negedge clk_pixel);
    clear_req = 1'b0;
    t0 = 0;
    while (acc_log.size() < 2 && t0 < 200) begin
      @(negedge clk_pixel);
      t0++;
    end
    cmd_valid = 1'b0;
    t0 = 0;
    while (done_log.size() < 2 && t0 < 200) begin
      @(negedge clk_pixel);
      t0++;
    end
    repeat (4) @(negedge clk_pixel);
    model('{1, 0, 0, 0, 0, CLAT}, nw);
    nwr = nw;
    model('{0, 1, 0, 3, 0, BLAT}, nw);
    chk("prio accepts", acc_log.size(), 2);
    chk("prio dones", done_log.size(), 2);
    chk("prio cmd after clear",
        acc_log.size() == 2 ? acc_log[1] - acc_log[0] : -1, CLAT);
    chk("prio blit lat",
        (acc_log.size() == 2 && done_log.size() == 2) ?
        done_log[1] - acc_log[1] : -1, BLAT);
    chk("prio writes", wa_log.size(), nwr + nw);
    img_chk("prio");

    // reset in BLIT cycle 10
    clr_logs();
    @(negedge clk_pixel);
    cmd_valid = 1'b1;
    cmd_x = 4'sd0;
    cmd_y = 3'sd0;
    cmd_frame = 2'd3;
    cmd_hflip = 1'b0;
    @(negedge clk_pixel);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk_pixel);
    chk("rstblit we before", fb_we, 1);
    sys_rst = 1'b1;
    @(negedge clk_pixel);
    chk("rstblit fb_we", fb_we, 0);
    chk("rstblit cmd_ready", cmd_ready, 1);
    chk("rstblit sheet_addr", sheet_addr, 0);
    sys_rst = 1'b0;
    nwr = wa_log.size();
    repeat (30) @(negedge clk_pixel);
    chk("rstblit no writes", wa_log.size(), nwr);
    chk("rstblit no done", done_log.size(), 0);
    do_op('{1, 0, 0, 0, 0, CLAT}, "reclear");

    for (int i = 0; i < 24; i++) begin
      rv.clr = 1'b0;
      rv.x = int'($urandom_range(0, 15)) - 8;
      rv.y = int'($urandom_range(0, 7)) - 4;
      rv.f = int'($urandom_range(0, NF - 1));
      rv.h = 1'($urandom_range(0, 1));
      rv.lat = BLAT;
      do_op(rv, $sformatf("rnd%0d x%0d y%0d", i, rv.x, rv.y));
    end

    chk("ready during clear", busy_ready, 0);
    chk("we while idle", idle_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SPRITE_FRAME_WIDTH, default 64, sprite frame width in pixels.
REQ-002 SHALL have parameter SPRITE_FRAME_HEIGHT, default 64, sprite frame height in pixels.
REQ-003 SHALL have parameter NUM_FRAMES, default 512, number of frames in the spritesheet.
REQ-004 SHALL have parameters CANVAS_WIDTH and CANVAS_HEIGHT, defaults 360 and 720, giving the canvas size in pixels.
REQ-005 SHALL have parameter PALETTE_SIZE, default 8; PW = $clog2(PALETTE_SIZE).
REQ-006 SHALL have parameter TRANSPARENT_INDEX, default 0, the palette index never written during a blit.
REQ-007 SHALL have parameter BG_INDEX, default PALETTE_SIZE-1, the index written by a clear.
REQ-008 SHALL have parameter ROM_LATENCY, default 2, cycles from sheet_addr to sheet_data.
REQ-009 SHALL have ports clk_pixel (in, 1: sole clock) and sys_rst (in, 1: synchronous, active-high reset).
REQ-010 SHALL have ports clear_req (in, 1) and clear_busy (out, 1): clear_req starts a canvas clear; clear_busy is high while a clear runs.
REQ-011 SHALL have ports cmd_valid (in, 1) and cmd_ready (out, 1) as the sprite-command handshake.
REQ-012 SHALL have port cmd_x (in, $clog2(CANVAS_WIDTH)+1, signed): sprite left edge, negative allowed.
REQ-013 SHALL have port cmd_y (in, $clog2(CANVAS_HEIGHT)+1, signed): sprite top edge, negative allowed.
REQ-014 SHALL have ports cmd_frame (in, $clog2(NUM_FRAMES)) and cmd_hflip (in, 1) giving the frame number and horizontal mirror.
REQ-015 SHALL have ports sheet_addr (out, $clog2(NUM_FRAMES*SPRITE_FRAME_WIDTH*SPRITE_FRAME_HEIGHT)) and sheet_data (in, PW) as the spritesheet read port.
REQ-016 SHALL have ports fb_we (out, 1), fb_addr (out, $clog2(CANVAS_WIDTH*CANVAS_HEIGHT)) and fb_din (out, PW) as the frame-buffer write port; fb_addr is row-major, y*CANVAS_WIDTH+x.
REQ-017 SHALL have port done (out, 1): a one-cycle pulse when a clear or a blit has fully retired.

Function
REQ-018 SHALL implement states IDLE, CLEAR, BLIT and DRAIN.
REQ-019 IDLE: cmd_ready=1; clear_req has priority over cmd_valid when both are high in the same cycle. clear_req enters CLEAR; a cmd_valid without clear_req is accepted and the command is latched.
REQ-020 cmd_ready SHALL be high only in IDLE; a command is accepted exactly on a cycle with cmd_valid&&cmd_ready.
REQ-021 CLEAR: SHALL write BG_INDEX to addresses 0..CANVAS_WIDTH*CANVAS_HEIGHT-1, one per cycle, with fb_we=1, then pulse done and return to IDLE. The clear takes CANVAS_WIDTH*CANVAS_HEIGHT cycles and clear_busy=1 throughout.
REQ-022 BLIT: SHALL step local (u,v) from (0,0) in row-major order, one per cycle, over SPRITE_FRAME_WIDTH*SPRITE_FRAME_HEIGHT cycles.
REQ-023 BLIT addressing: sheet_addr = cmd_frame*W*H + v*W + (cmd_hflip ? W-1-u : u), where W = SPRITE_FRAME_WIDTH and H = SPRITE_FRAME_HEIGHT.
REQ-024 SHALL delay the target coordinates (cmd_x+u, cmd_y+v) and a valid bit by ROM_LATENCY cycles so they align with sheet_data.
REQ-025 Aligned pixel: fb_we=1 only if the delayed valid bit is set, sheet_data != TRANSPARENT_INDEX, 0 <= x < CANVAS_WIDTH and 0 <= y < CANVAS_HEIGHT; in that case fb_din=sheet_data. Otherwise fb_we=0.
REQ-026 After the last (u,v) is issued, the block SHALL enter DRAIN for ROM_LATENCY cycles, then pulse done and return to IDLE. The latency from command accept to done is W*H+ROM_LATENCY+1 cycles.
REQ-027 A sprite lying wholly off-canvas SHALL still consume the full timing and produce zero writes.
REQ-028 Coordinate arithmetic SHALL be signed and one bit wider than the canvas coordinate, so that no wrap-around occurs for -W < cmd_x < CANVAS_WIDTH.
REQ-029 clear_req outside IDLE SHALL be ignored (not queued); cmd inputs are don't-care while cmd_ready=0.
REQ-030 fb_we SHALL be 0 in IDLE, and fb_din and fb_addr are don't-care when fb_we=0.

Reset
REQ-031 sys_rst SHALL, on the next edge, force IDLE with cmd_ready=1, clear_busy=0, done=0, fb_we=0, sheet_addr=0 and all pipeline valid bits cleared.
REQ-032 sys_rst mid-CLEAR or mid-BLIT SHALL abort the operation with no further fb_we and no done pulse; frame-buffer contents are left partially written.

Verification
REQ-033 Clear: with 8x4 canvas, pulse clear_req -> 32 consecutive fb_we with fb_addr 0..31 and fb_din=7, then done high exactly 1 cycle later.
REQ-034 Blit with transparency: frame 1 at (2,3), with sheet pixel index 0 at u=0,v=0 -> no write to 3*CANVAS_WIDTH+2; all other non-zero pixels written; done at accept+W*H+ROM_LATENCY+1.
REQ-035 Flip and clip: cmd_x=-2, cmd_hflip=1 -> columns u=0,1 produce no writes; column u=2 writes x=0 using sheet column W-3.
REQ-036 Priority: clear_req and cmd_valid high in the same IDLE cycle -> clear runs, cmd_ready=0 throughout, and the command is accepted only afterwards.
REQ-037 Reset mid-blit: assert sys_rst at cycle 10 of BLIT -> fb_we=0 on the following cycle, no done pulse, and cmd_ready=1.
REQ-038 Off-canvas: cmd_x=CANVAS_WIDTH-1+W -> zero fb_we, with done pulsing on schedule.
